burst_fifo_probe: RTL and testbench
===================================

BURST_FIFO_PROBE -- requirements
Module: burst_fifo_probe

Interface
REQ-001 SHALL have parameter DATA_W, default 8, FIFO payload width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH_W, default 2, giving FIFO depth DEPTH = 2**FIFO_DEPTH_W entries.
REQ-003 SHALL have parameter CNT_W, default 16, giving the width of all configuration inputs and counters.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk_i  input  1  sole clock, rising edge; rst_i  input  1  asynchronous active-high reset.
REQ-005 SHALL have start_i  input  1  single-cycle run request.
REQ-006 SHALL have wr_burst_size_i, wr_idle_i, wr_num_bursts_i  input  CNT_W each  writer burst length, gap cycles between bursts, and burst count.
REQ-007 SHALL have rd_burst_size_i, rd_idle_i  input  CNT_W each  reader burst length and gap cycles.
REQ-008 SHALL have busy_o  output  1  run in progress; done_o  output  1  run complete, sticky.
REQ-009 SHALL have wr_count_o, rd_count_o  output  CNT_W each  accepted writes and reads.
REQ-010 SHALL have max_level_o  output  FIFO_DEPTH_W+1  peak FIFO occupancy.
REQ-011 SHALL have error_o  output  1  sticky read-data order mismatch.
REQ-012 SHALL have wr_stall_o, rd_stall_o  output  CNT_W each  stall-cycle counters (see Configuration).

Function
REQ-013 SHALL contain a single-clock circular FIFO of DEPTH x DATA_W with occupancy level 0..DEPTH; full when level == DEPTH, empty when level == 0.
REQ-014 SHALL latch all configuration inputs on an accepted start_i; start_i while busy_o=1 SHALL be ignored.
REQ-015 Accepted start SHALL clear the counters, max_level_o, error_o, and done_o, and SHALL set busy_o on the next cycle.
REQ-016 Writer FSM SHALL have states IDLE, BURST, GAP, and FIN; start moves IDLE->BURST, or IDLE->FIN if wr_num_bursts == 0.
REQ-017 In BURST, the writer SHALL request a write every cycle; a write SHALL be accepted only when not full, decided on the registered full flag regardless of a same-cycle read.
REQ-018 Written data SHALL be a DATA_W incrementing sequence starting at 0 per run, wrapping modulo 2**DATA_W, and SHALL advance only on an accepted write.
REQ-019 After wr_burst_size accepted writes, the writer SHALL go BURST->GAP for wr_idle cycles, then back to BURST; wr_idle == 0 SHALL skip GAP; burst size 0 SHALL be treated as 1.
REQ-020 After the wr_num_bursts-th burst completes, the writer SHALL enter FIN.
REQ-021 Reader FSM SHALL have states IDLE, BURST, and GAP and SHALL enter BURST on start; in BURST it SHALL read when not empty, decided on registered empty.
REQ-022 After rd_burst_size accepted reads, the reader SHALL spend rd_idle cycles in GAP (0 skips GAP, size 0 treated as 1).
REQ-023 Write-to-read latency SHALL be 1 cycle: data written in cycle N SHALL be readable in cycle N+1 at the earliest.
REQ-024 Simultaneous accepted read and write SHALL leave the level unchanged; pointers SHALL wrap at DEPTH.
REQ-025 Each read value SHALL be compared to an expected sequence counter; any mismatch SHALL set error_o until the next start.
REQ-026 max_level_o SHALL update each cycle to the maximum of itself and the post-update level.
REQ-027 Counters SHALL saturate at 2**CNT_W-1.
REQ-028 When the writer is in FIN and the FIFO is empty, the block SHALL clear busy_o, set done_o on the next cycle, and return both FSMs to IDLE.

Reset
REQ-029 rst_i SHALL immediately force both FSMs to IDLE, empty the FIFO, zero pointers, and drive every output to 0, including mid-run.
REQ-030 After rst_i deasserts, the block SHALL remain idle until start_i.

Configuration
REQ-031 Macro BURST_FIFO_PROBE_STALL_COUNT_EN defined: wr_stall_o SHALL count cycles the writer is in BURST with FIFO full, and rd_stall_o SHALL count cycles the reader is in BURST with FIFO empty.
REQ-032 Macro undefined: wr_stall_o and rd_stall_o SHALL be constant 0 and no stall counter logic SHALL be present.

Verification
REQ-033 FIFO_DEPTH_W=2, write 4x4 with idle 0, read 4 with idle 0 -> done_o, wr_count=rd_count=16, error_o=0, max_level_o <= 2.
REQ-034 Write 1x8 with idle 0, read 1 with idle 3, depth 4 -> max_level_o=4, wr_stall_o>0 (macro on), done_o, counts 8/8.
REQ-035 wr_num_bursts=0 -> done_o within 2 cycles of start, all counts 0.
REQ-036 DATA_W=2, 10 writes -> data wraps 3->0, error_o=0.
REQ-037 rst_i asserted mid-run at wr_count=5 -> all outputs 0 in the same cycle; a new start runs clean to completion.
REQ-038 start_i pulsed while busy_o=1 -> ignored, results identical to an unperturbed run.

Source files
------------

// File: rtl/burst_fifo_probe.sv
// burst_fifo_probe: bursty writer and bursty reader around a small circular FIFO,
// reporting traffic counts, peak occupancy and read-order errors.
// Optional stall counters are built only when BURST_FIFO_PROBE_STALL_COUNT_EN is defined.
module burst_fifo_probe #(
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH_W = 2,
  parameter int CNT_W        = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [CNT_W-1:0]      wr_burst_size_i,
  input  logic [CNT_W-1:0]      wr_idle_i,
  input  logic [CNT_W-1:0]      wr_num_bursts_i,
  input  logic [CNT_W-1:0]      rd_burst_size_i,
  input  logic [CNT_W-1:0]      rd_idle_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_W-1:0]      wr_count_o,
  output logic [CNT_W-1:0]      rd_count_o,
  output logic [FIFO_DEPTH_W:0] max_level_o,
  output logic                  error_o,
  output logic [CNT_W-1:0]      wr_stall_o,
  output logic [CNT_W-1:0]      rd_stall_o
);
  localparam int                      DEPTH    = 2 ** FIFO_DEPTH_W;
  localparam logic [FIFO_DEPTH_W:0]   LVL_FULL = (FIFO_DEPTH_W + 1)'(DEPTH);
  localparam logic [FIFO_DEPTH_W:0]   LVL_ONE  = (FIFO_DEPTH_W + 1)'(1);
  localparam logic [FIFO_DEPTH_W-1:0] PTR_ONE  = FIFO_DEPTH_W'(1);
  localparam logic [DATA_W-1:0]       DAT_ONE  = DATA_W'(1);
  localparam logic [CNT_W-1:0]        CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]        CNT_MAX  = '1;

  typedef enum logic [1:0] {W_IDLE, W_BURST, W_GAP, W_FIN} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_BURST, R_GAP} rd_state_t;

  wr_state_t wr_state, wr_state_nxt;
  rd_state_t rd_state, rd_state_nxt;

  // latched run configuration (burst sizes already promoted from 0 to 1)
  logic [CNT_W-1:0] cfg_wr_size, cfg_wr_idle, cfg_wr_num, cfg_rd_size, cfg_rd_idle;

  logic [CNT_W-1:0] wr_beat, wr_bursts, wr_gap;
  logic [CNT_W-1:0] rd_beat, rd_gap;

  logic [DATA_W-1:0]       mem [DEPTH];
  logic [FIFO_DEPTH_W-1:0] wptr, rptr;
  logic [FIFO_DEPTH_W:0]   level, level_nxt;
  logic [DATA_W-1:0]       wr_data, rd_expect, rd_data;

  logic start_ok, finish, full, empty;
  logic wr_req, rd_req, wr_en, rd_en;
  logic wr_last_beat, wr_last_burst, wr_gap_end;
  logic rd_last_beat, rd_gap_end;

  assign start_ok = start_i && !busy_o;
  assign full     = (level == LVL_FULL);
  assign empty    = (level == '0);
  // the run ends only once the writer has finished and everything written was drained
  assign finish   = (wr_state == W_FIN) && empty;

  assign wr_en         = wr_req && !full;
  assign rd_en         = rd_req && !empty;
  assign wr_last_beat  = wr_en && (wr_beat == cfg_wr_size - CNT_ONE);
  assign wr_last_burst = (wr_bursts == cfg_wr_num - CNT_ONE);
  assign wr_gap_end    = (wr_gap == cfg_wr_idle - CNT_ONE);
  assign rd_last_beat  = rd_en && (rd_beat == cfg_rd_size - CNT_ONE);
  assign rd_gap_end    = (rd_gap == cfg_rd_idle - CNT_ONE);
  assign rd_data       = mem[rptr];

  // run control: accept a start only when idle, latch configuration, end when drained
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      cfg_wr_size <= '0;
      cfg_wr_idle <= '0;
      cfg_wr_num  <= '0;
      cfg_rd_size <= '0;
      cfg_rd_idle <= '0;
    end else if (start_ok) begin
      busy_o      <= 1'b1;
      done_o      <= 1'b0;
      cfg_wr_size <= (wr_burst_size_i == '0) ? CNT_ONE : wr_burst_size_i;
      cfg_wr_idle <= wr_idle_i;
      cfg_wr_num  <= wr_num_bursts_i;
      cfg_rd_size <= (rd_burst_size_i == '0) ? CNT_ONE : rd_burst_size_i;
      cfg_rd_idle <= rd_idle_i;
    end else if (finish) begin
      busy_o <= 1'b0;
      done_o <= 1'b1;
    end
  end

  // writer state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) wr_state <= W_IDLE;
    else       wr_state <= wr_state_nxt;
  end

  // writer next state: bursts separated by optional gaps, then wait in FIN for the drain
  always_comb begin
    wr_state_nxt = wr_state;
    case (wr_state)
      W_IDLE:  if (start_ok) wr_state_nxt = (wr_num_bursts_i == '0) ? W_FIN : W_BURST;
      W_BURST: if (wr_last_beat) begin
                 if (wr_last_burst)           wr_state_nxt = W_FIN;
                 else if (cfg_wr_idle != '0)  wr_state_nxt = W_GAP;
               end
      W_GAP:   if (wr_gap_end) wr_state_nxt = W_BURST;
      W_FIN:   if (finish) wr_state_nxt = W_IDLE;
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  // writer output: request a write on every BURST cycle
  always_comb begin
    wr_req = (wr_state == W_BURST);
  end

  // writer progress: beats within the burst, completed bursts, gap cycles
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_beat   <= '0;
      wr_bursts <= '0;
      wr_gap    <= '0;
    end else if (start_ok) begin
      wr_beat   <= '0;
      wr_bursts <= '0;
      wr_gap    <= '0;
    end else begin
      if (wr_last_beat) begin
        wr_beat   <= '0;
        wr_bursts <= wr_bursts + CNT_ONE;
      end else if (wr_en) begin
        wr_beat <= wr_beat + CNT_ONE;
      end
      wr_gap <= (wr_state == W_GAP) ? wr_gap + CNT_ONE : '0;
    end
  end

  // reader state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rd_state <= R_IDLE;
    else       rd_state <= rd_state_nxt;
  end

  // reader next state: alternate bursts and gaps until the run finishes
  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      R_IDLE:  if (start_ok) rd_state_nxt = R_BURST;
      R_BURST: if (finish) rd_state_nxt = R_IDLE;
               else if (rd_last_beat && cfg_rd_idle != '0) rd_state_nxt = R_GAP;
      R_GAP:   if (finish) rd_state_nxt = R_IDLE;
               else if (rd_gap_end) rd_state_nxt = R_BURST;
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  // reader output: request a read on every BURST cycle
  always_comb begin
    rd_req = (rd_state == R_BURST);
  end

  // reader progress: beats within the burst and gap cycles
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_beat <= '0;
      rd_gap  <= '0;
    end else if (start_ok) begin
      rd_beat <= '0;
      rd_gap  <= '0;
    end else begin
      if (rd_last_beat)  rd_beat <= '0;
      else if (rd_en)    rd_beat <= rd_beat + CNT_ONE;
      rd_gap <= (rd_state == R_GAP) ? rd_gap + CNT_ONE : '0;
    end
  end

  // next occupancy: a simultaneous read and write cancel out
  always_comb begin
    level_nxt = level;
    if (wr_en && !rd_en)      level_nxt = level + LVL_ONE;
    else if (!wr_en && rd_en) level_nxt = level - LVL_ONE;
  end

  // FIFO pointers, occupancy, peak tracking and the write/expected-read sequences
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr        <= '0;
      rptr        <= '0;
      level       <= '0;
      max_level_o <= '0;
      wr_data     <= '0;
      rd_expect   <= '0;
    end else if (start_ok) begin
      wptr        <= '0;
      rptr        <= '0;
      level       <= '0;
      max_level_o <= '0;
      wr_data     <= '0;
      rd_expect   <= '0;
    end else begin
      if (wr_en) begin
        wptr    <= wptr + PTR_ONE;
        wr_data <= wr_data + DAT_ONE;
      end
      if (rd_en) begin
        rptr      <= rptr + PTR_ONE;
        rd_expect <= rd_expect + DAT_ONE;
      end
      level <= level_nxt;
      if (level_nxt > max_level_o) max_level_o <= level_nxt;
    end
  end

  // storage array; contents are meaningless while the level says empty
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wptr] <= wr_data;
  end

  // saturating traffic counters and sticky order-error flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_count_o <= '0;
      rd_count_o <= '0;
      error_o    <= 1'b0;
    end else if (start_ok) begin
      wr_count_o <= '0;
      rd_count_o <= '0;
      error_o    <= 1'b0;
    end else begin
      if (wr_en && wr_count_o != CNT_MAX) wr_count_o <= wr_count_o + CNT_ONE;
      if (rd_en && rd_count_o != CNT_MAX) rd_count_o <= rd_count_o + CNT_ONE;
      if (rd_en && rd_data != rd_expect)  error_o <= 1'b1;
    end
  end

`ifdef BURST_FIFO_PROBE_STALL_COUNT_EN
  logic [CNT_W-1:0] wr_stall, rd_stall;

  // stall counters: writer blocked by full, reader starved by empty
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_stall <= '0;
      rd_stall <= '0;
    end else if (start_ok) begin
      wr_stall <= '0;
      rd_stall <= '0;
    end else begin
      if (wr_req && full && wr_stall != CNT_MAX)  wr_stall <= wr_stall + CNT_ONE;
      if (rd_req && empty && rd_stall != CNT_MAX) rd_stall <= rd_stall + CNT_ONE;
    end
  end

  assign wr_stall_o = wr_stall;
  assign rd_stall_o = rd_stall;
`else
  assign wr_stall_o = '0;
  assign rd_stall_o = '0;
`endif

endmodule

// File: tb/tb_burst_fifo_probe.sv
// Bench for burst_fifo_probe: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized runs.
module tb_burst_fifo_probe;
  localparam int DEPTH   = 4;
  localparam int CNT_MAX = 65535;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] wr_size, wr_idle, wr_num, rd_size, rd_idle;

  logic        a_busy, a_done, a_err, b_busy, b_done, b_err;
  logic [15:0] a_wc, a_rc, a_ws, a_rs, b_wc, b_rc, b_ws, b_rs;
  logic [2:0]  a_ml, b_ml;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 0;

  always #5 clk = ~clk;

  burst_fifo_probe dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .wr_burst_size_i(wr_size), .wr_idle_i(wr_idle), .wr_num_bursts_i(wr_num),
    .rd_burst_size_i(rd_size), .rd_idle_i(rd_idle),
    .busy_o(a_busy), .done_o(a_done), .wr_count_o(a_wc), .rd_count_o(a_rc),
    .max_level_o(a_ml), .error_o(a_err), .wr_stall_o(a_ws), .rd_stall_o(a_rs)
  );

  burst_fifo_probe #(.DATA_W(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .wr_burst_size_i(wr_size), .wr_idle_i(wr_idle), .wr_num_bursts_i(wr_num),
    .rd_burst_size_i(rd_size), .rd_idle_i(rd_idle),
    .busy_o(b_busy), .done_o(b_done), .wr_count_o(b_wc), .rd_count_o(b_rc),
    .max_level_o(b_ml), .error_o(b_err), .wr_stall_o(b_ws), .rd_stall_o(b_rs)
  );

  // ---------------- reference model ----------------
  bit m_busy, m_done, m_err;
  int m_wc, m_rc, m_max, m_wst, m_rst;
  int m_bursts_left, m_wbeats, m_wgap, m_rbeats, m_rgap, m_wdata, m_exp;
  int c_wsize, c_widle, c_rsize, c_ridle;
  int q[$];

  function automatic int sat(input int x);
    return (x > CNT_MAX) ? CNT_MAX : x;
  endfunction

  task automatic model_clear();
    m_busy = 0; m_done = 0; m_err = 0;
    m_wc = 0; m_rc = 0; m_max = 0; m_wst = 0; m_rst = 0;
    m_bursts_left = 0; m_wbeats = 0; m_wgap = 0; m_rbeats = 0; m_rgap = 0;
    m_wdata = 0; m_exp = 0;
    q.delete();
  endtask

  task automatic model_step();
    bit st_ok, wb, wg, rb, rg, full, empty, we, re, fin;
    int v;
    st_ok = start && !m_busy;
    wb    = m_busy && m_bursts_left > 0 && m_wgap == 0;
    wg    = m_busy && m_wgap > 0;
    rb    = m_busy && m_rgap == 0;
    rg    = m_busy && m_rgap > 0;
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    we    = wb && !full;
    re    = rb && !empty;
    fin   = m_busy && m_bursts_left == 0 && empty;
    if (wb && full)  m_wst = sat(m_wst + 1);
    if (rb && empty) m_rst = sat(m_rst + 1);
    if (wg) m_wgap--;
    if (rg) m_rgap--;
    if (re) begin
      v = q.pop_front();
      if (v != m_exp) m_err = 1;
      m_exp = (m_exp + 1) % 256;
      m_rc  = sat(m_rc + 1);
      m_rbeats--;
      if (m_rbeats == 0) begin
        m_rbeats = c_rsize;
        m_rgap   = c_ridle;
      end
    end
    if (we) begin
      q.push_back(m_wdata);
      m_wdata = (m_wdata + 1) % 256;
      m_wc    = sat(m_wc + 1);
      m_wbeats--;
      if (m_wbeats == 0) begin
        m_bursts_left--;
        m_wbeats = c_wsize;
        m_wgap   = (m_bursts_left > 0) ? c_widle : 0;
      end
    end
    if (q.size() > m_max) m_max = q.size();
    if (fin) begin
      m_busy = 0; m_done = 1; m_wgap = 0; m_rgap = 0;
    end
    if (st_ok) begin
      m_busy = 1; m_done = 0; m_err = 0;
      m_wc = 0; m_rc = 0; m_max = 0; m_wst = 0; m_rst = 0;
      c_wsize = (wr_size == 0) ? 1 : int'(wr_size);
      c_rsize = (rd_size == 0) ? 1 : int'(rd_size);
      c_widle = int'(wr_idle);
      c_ridle = int'(rd_idle);
      m_bursts_left = int'(wr_num);
      m_wbeats = c_wsize; m_rbeats = c_rsize;
      m_wgap = 0; m_rgap = 0; m_wdata = 0; m_exp = 0;
      q.delete();
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_clear();
    else     model_step();
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_dut(input string tag, input logic busy, input logic done,
                         input logic [15:0] wc, input logic [15:0] rc, input logic [2:0] ml,
                         input logic err, input logic [15:0] ws, input logic [15:0] rs,
                         input int e_busy, input int e_done, input int e_wc, input int e_rc,
                         input int e_ml, input int e_err, input int e_ws, input int e_rs);
    chk({tag, ".busy"},  32'(busy), e_busy);
    chk({tag, ".done"},  32'(done), e_done);
    chk({tag, ".wr_cnt"}, 32'(wc), e_wc);
    chk({tag, ".rd_cnt"}, 32'(rc), e_rc);
    chk({tag, ".max_lvl"}, 32'(ml), e_ml);
    chk({tag, ".error"}, 32'(err), e_err);
    chk({tag, ".wr_stall"}, 32'(ws), e_ws);
    chk({tag, ".rd_stall"}, 32'(rs), e_rs);
  endtask

  task automatic check_zero(input string tag);
    chk_dut({tag, ".a"}, a_busy, a_done, a_wc, a_rc, a_ml, a_err, a_ws, a_rs, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_dut({tag, ".b"}, b_busy, b_done, b_wc, b_rc, b_ml, b_err, b_ws, b_rs, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    int e_ws, e_rs;
    #1;
    if (!rst && cmp_en) begin
`ifdef BURST_FIFO_PROBE_STALL_COUNT_EN
      e_ws = m_wst; e_rs = m_rst;
`else
      e_ws = 0; e_rs = 0;
`endif
      chk_dut("cyc.a", a_busy, a_done, a_wc, a_rc, a_ml, a_err, a_ws, a_rs,
              int'(m_busy), int'(m_done), m_wc, m_rc, m_max, int'(m_err), e_ws, e_rs);
      chk_dut("cyc.b", b_busy, b_done, b_wc, b_rc, b_ml, b_err, b_ws, b_rs,
              int'(m_busy), int'(m_done), m_wc, m_rc, m_max, int'(m_err), e_ws, e_rs);
    end
  end

  // ---------------- stimulus ----------------
  task automatic scramble_cfg();
    wr_size = 16'($urandom); wr_idle = 16'($urandom); wr_num = 16'($urandom);
    rd_size = 16'($urandom); rd_idle = 16'($urandom);
  endtask

  task automatic start_run(input int ws, input int wi, input int wn, input int rs, input int ri);
    @(negedge clk);
    wr_size = 16'(ws); wr_idle = 16'(wi); wr_num = 16'(wn);
    rd_size = 16'(rs); rd_idle = 16'(ri);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble_cfg();
  endtask

  task automatic wait_done(input int budget, input bit perturb, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (a_done) begin
        ok = 1;
        break;
      end
      if (perturb && m_busy && $urandom_range(0, 3) == 0) begin
        scramble_cfg();
        start = 1'b1;
      end
    end
    start = 1'b0;
  endtask

  task automatic run_and_check(input string name, input int ws, input int wi, input int wn,
                               input int rs, input int ri, input bit perturb);
    bit ok;
    int exp_n;
    exp_n = wn * ((ws == 0) ? 1 : ws);
    start_run(ws, wi, wn, rs, ri);
    wait_done(2000, perturb, ok);
    chk({name, ".finished"}, 32'(ok), 1);
    chk({name, ".a_wr"}, 32'(a_wc), exp_n);
    chk({name, ".a_rd"}, 32'(a_rc), exp_n);
    chk({name, ".b_wr"}, 32'(b_wc), exp_n);
    chk({name, ".a_err"}, 32'(a_err), 0);
    chk({name, ".b_err"}, 32'(b_err), 0);
    chk({name, ".a_busy"}, 32'(a_busy), 0);
  endtask

  initial begin
    bit found;
    int save_max, save_wst;
    start = 1'b0;
    wr_size = '0; wr_idle = '0; wr_num = '0; rd_size = '0; rd_idle = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset_hold");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_zero("idle_after_reset");
    cmp_en = 1;

    // 4 bursts of 4, no gaps, reader 4 no gaps
    run_and_check("b4x4", 4, 0, 4, 4, 0, 0);
    chk("b4x4.max_le2", 32'(a_ml <= 3'd2), 1);
    chk("b4x4.model_wr", m_wc, 16);

    // single-beat bursts against a slow reader: FIFO fills up
    run_and_check("fill", 1, 0, 8, 1, 3, 0);
    chk("fill.max", 32'(a_ml), 4);
    chk("fill.model_max", m_max, 4);
`ifdef BURST_FIFO_PROBE_STALL_COUNT_EN
    chk("fill.wr_stall_pos", 32'(a_ws > 16'd0), 1);
`endif

    // zero bursts: done two cycles after start, nothing moved
    start_run(3, 1, 0, 2, 1);
    chk("zero.busy_mid", 32'(a_busy), 1);
    chk("zero.done_mid", 32'(a_done), 0);
    @(negedge clk);
    chk("zero.done", 32'(a_done), 1);
    chk("zero.busy", 32'(a_busy), 0);
    chk("zero.wr", 32'(a_wc), 0);
    chk("zero.rd", 32'(a_rc), 0);

    // narrow-data instance wraps 3->0 twice over ten writes
    run_and_check("wrap10", 10, 0, 1, 3, 1, 0);
    chk("wrap10.b_err", 32'(b_err), 0);
    chk("wrap10.b_rd", 32'(b_rc), 10);

    // reset in the middle of a run
    start_run(3, 1, 4, 2, 2);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (a_wc == 16'd5) begin
        found = 1;
        break;
      end
    end
    chk("midrst.reached5", 32'(found), 1);
    #2 rst = 1'b1;
    #1 check_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("midrst_idle");
    run_and_check("after_rst", 3, 1, 4, 2, 2, 0);

    // start pulses while busy are ignored
    run_and_check("plain", 3, 1, 2, 3, 2, 0);
    save_max = m_max;
    save_wst = m_wst;
    run_and_check("perturbed", 3, 1, 2, 3, 2, 1);
    chk("perturbed.max", 32'(a_ml), save_max);
    chk("perturbed.model_wst", m_wst, save_wst);
    chk("perturbed.wr", 32'(a_wc), 6);

    // randomized runs with occasional ignored starts
    for (int r = 0; r < 30; r++) begin
      run_and_check("rand", $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 5),
                    $urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #600000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete, errors %0d", n_errors);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
